alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- sequencer in front of a shared combinational ALU.
//
// Accepts one operation at a time (in_valid/in_ready). It drives the latched
// operands to the external ALU for one EXEC cycle, registers the answer into
// out_res, and holds it in DONE until out_valid/out_ready completes.
//
// Multiply (func 10) is optional. It is a shift-and-add loop that reuses the
// ALU adder for MUL_ITER cycles.
//
// Configuration macro: ALU_MUL_EN
//   defined   : func 10 runs the multiply sequence.
//   undefined : func 10 is treated like the reserved codes (result 0).
//
// Ports
//   clk, rstn              clock, async active-low reset
//   in_valid/in_ready      request handshake; in_ready is high only in IDLE
//   in_func, in_a, in_b    op code and operands, latched on accept
//   out_valid/out_ready    result handshake; out_res is held while waiting
//   out_res                registered result
//   alu_src1/2, alu_func   drive to the shared ALU
//   alu_ans                ALU combinational answer
//   busy                   high whenever not IDLE
module alu_seq_ctrl #(
  parameter int MUL_ITER = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_func,
  input  logic [31:0] alu_ans,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  func_q, func_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d;

`ifdef ALU_MUL_EN
  localparam logic [5:0] CNT_LAST = 6'(MUL_ITER - 1);
  logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [5:0]  cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^MUL_ITER;
`endif

  // Codes 0-9 go to the ALU. In EXEC, 10 only shows up when multiply is
  // disabled, so it falls in with 11-15 as "answer is zero".
  logic legal_op;
  assign legal_op = (func_q <= 4'd9);

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_res   = res_q;

  always_comb begin
    alu_src1 = 32'd0;
    alu_src2 = 32'd0;
    alu_func = 4'd0;
    case (state_q)
      S_EXEC: if (legal_op) begin
        alu_src1 = a_q;
        // Shifts only use a 5-bit amount.
        alu_src2 = (func_q == 4'd8 || func_q == 4'd9) ? {27'b0, b_q[4:0]} : b_q;
        alu_func = func_q;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        alu_src1 = acc_q;
        alu_src2 = mcand_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        func_d  = in_func;
        a_d     = in_a;
        b_d     = in_b;
        state_d = S_EXEC;
`ifdef ALU_MUL_EN
        if (in_func == 4'd10) begin
          state_d  = S_MUL;
          acc_d    = 32'd0;
          mcand_d  = in_a;
          mplier_d = in_b;
          cnt_d    = 6'd0;
        end
`endif
      end
      S_EXEC: begin
        res_d   = legal_op ? alu_ans : 32'd0;
        state_d = S_DONE;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (mplier_q[0]) acc_d = alu_ans;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        // Last iteration: take this cycle's partial sum straight into the
        // result so DONE arrives without an extra cycle.
        if (cnt_q == CNT_LAST) begin
          res_d   = mplier_q[0] ? alu_ans : acc_q;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      func_q  <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      cnt_q    <= 6'd0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule
